// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter sharing one UART transmit channel among N_REQ
//   byte-stream requesters. Each grant carries one message: an optional tag
//   byte (8'hF0 | grant_id), then data bytes until the requester marks last,
//   MAX_BURST bytes have been sent, or the requester stalls for
//   STALL_TIMEOUT consecutive cycles (grant revoked, abort pulses).
//
// Ports
//   clk        single clock
//   rst        asynchronous, active-low reset
//   req_data   requester i byte at [i*DATA_BITS +: DATA_BITS]
//   req_valid  per-requester byte valid
//   req_last   per-requester end-of-message, qualified by valid
//   req_ready  per-requester accept (at most one bit high)
//   tx_data    byte to UART driver
//   tx_valid   byte valid to UART driver
//   tx_ready   UART driver idle / accept
//   grant_id   current or most recent grantee (registered)
//   busy       high while a grant is active (registered)
//   abort      one-cycle pulse after a timeout revocation (registered)
module uart_tx_arbiter #(
  parameter int N_REQ         = 4,
  parameter int DATA_BITS     = 8,
  parameter int MAX_BURST     = 16,
  parameter int TAG_ENABLE    = 1,
  parameter int STALL_TIMEOUT = 1024,
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1,
  localparam int SW = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ*DATA_BITS-1:0] req_data,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  output logic [DATA_BITS-1:0]       tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [GW-1:0]              grant_id,
  output logic                       busy,
  output logic                       abort
);

  typedef enum logic [1:0] {S_IDLE, S_TAG, S_DATA} state_t;

  localparam logic [DATA_BITS-1:0] TAG_BASE = DATA_BITS'(8'hF0);

  state_t               state, state_nxt;
  logic [GW-1:0]        last_grant, last_grant_nxt, grant_nxt;
  logic [BW-1:0]        burst_cnt, burst_nxt;
  logic [SW-1:0]        stall_cnt, stall_nxt;
  logic                 abort_nxt;

  logic [GW-1:0]        rr_idx, rr_pick;
  logic                 rr_any;
  logic [DATA_BITS-1:0] g_data;
  logic                 g_valid, g_last;

  // Round-robin search: first requesting index after last_grant, wrapping.
  always_comb begin
    rr_idx  = '0;
    rr_pick = '0;
    rr_any  = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      rr_idx = GW'((32'(last_grant) + k) % 32'(N_REQ));
      if (!rr_any && req_valid[rr_idx]) begin
        rr_any  = 1'b1;
        rr_pick = rr_idx;
      end
    end
  end

  assign g_data  = req_data[32'(grant_id) * DATA_BITS +: DATA_BITS];
  assign g_valid = req_valid[grant_id];
  assign g_last  = req_last[grant_id];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      grant_id   <= '0;
      last_grant <= GW'(N_REQ - 1);
      burst_cnt  <= '0;
      stall_cnt  <= '0;
      abort      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant_id   <= grant_nxt;
      last_grant <= last_grant_nxt;
      burst_cnt  <= burst_nxt;
      stall_cnt  <= stall_nxt;
      abort      <= abort_nxt;
      busy       <= (state_nxt != S_IDLE);
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_id;
    last_grant_nxt = last_grant;
    burst_nxt      = burst_cnt;
    stall_nxt      = stall_cnt;
    abort_nxt      = 1'b0;
    tx_valid       = 1'b0;
    tx_data        = '0;
    req_ready      = '0;
    case (state)
      S_IDLE: begin
        burst_nxt = '0;
        stall_nxt = '0;
        if (rr_any) begin
          grant_nxt = rr_pick;
          state_nxt = (TAG_ENABLE != 0) ? S_TAG : S_DATA;
        end
      end
      S_TAG: begin
        tx_valid = 1'b1;
        tx_data  = TAG_BASE | DATA_BITS'(grant_id);
        if (tx_ready) state_nxt = S_DATA;
      end
      S_DATA: begin
        tx_valid            = g_valid;
        tx_data             = g_data;
        req_ready[grant_id] = tx_ready;
        if (g_valid) begin
          // Waiting on the driver is not a requester stall.
          stall_nxt = '0;
          if (tx_ready) begin
            burst_nxt = burst_cnt + BW'(1);
            if (g_last || (burst_cnt == BW'(MAX_BURST - 1))) begin
              last_grant_nxt = grant_id;
              state_nxt      = S_IDLE;
            end
          end
        end else if (stall_cnt == SW'(STALL_TIMEOUT - 1)) begin
          abort_nxt      = 1'b1;
          last_grant_nxt = grant_id;
          state_nxt      = S_IDLE;
        end else begin
          stall_nxt = stall_cnt + SW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Self-checking bench for uart_tx_arbiter (N_REQ=4, MAX_BURST=4,
//   STALL_TIMEOUT=8, TAG_ENABLE=1). Requesters are byte queues; the driver
//   model drops tx_ready for a random 1..3 cycles after each transfer. A
//   message-level model turns the loaded queues into the expected transmit
//   stream (tag + bytes, with grantee) from the round-robin rules.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int ST = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [DW-1:0]   tx_data;
  logic            tx_valid, tx_ready;
  logic [1:0]      grant_id;
  logic            busy, abort;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ(N), .DATA_BITS(DW), .MAX_BURST(MB), .TAG_ENABLE(1), .STALL_TIMEOUT(ST)
  ) dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .grant_id(grant_id),
    .busy(busy), .abort(abort)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] bd [N][64];
  bit         bl [N][64];
  int         head [N];
  int         tail [N];
  bit         en [N];
  logic [7:0] ed [$];
  int         eg [$];
  int         m_last;
  int         cool;
  bit         hold;
  logic       obs_v, obs_ab, obs_busy, obs_x;
  logic [7:0] obs_d;
  int         nx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input bit l);
    bd[i][tail[i]] = d;
    bl[i][tail[i]] = l;
    tail[i]++;
  endtask

  task automatic clear_q();
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
      en[i]   = 1'b0;
    end
  endtask

  task automatic drive();
    bit v;
    for (int i = 0; i < N; i++) begin
      v = en[i] && (head[i] < tail[i]);
      req_valid[i]         = v;
      req_data[i*DW +: DW] = v ? bd[i][head[i]] : 8'h00;
      req_last[i]          = v && bl[i][head[i]];
    end
    tx_ready = !hold && (cool == 0);
  endtask

  // One clock: drive at negedge, observe 1 ns later, score any transfer.
  task automatic cycle();
    @(negedge clk);
    drive();
    #1;
    obs_v    = tx_valid;
    obs_d    = tx_data;
    obs_ab   = abort;
    obs_busy = busy;
    obs_x    = tx_valid && tx_ready;
    chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
    if (obs_x) begin
      nx++;
      if (ed.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_xfer: observed=%0h expected=none", obs_d);
      end else begin
        chk("tx_byte", obs_d, ed.pop_front());
        chk("xfer_grant_id", grant_id, eg.pop_front());
      end
      cool = 1 + $urandom_range(0, 2);
    end else if (cool > 0) begin
      cool--;
    end
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i]) head[i]++;
  endtask

  // Message-level model: round-robin over requesters holding data.
  task automatic build();
    int h [N];
    int g, n, c;
    bit any;
    for (int i = 0; i < N; i++) h[i] = head[i];
    while (1) begin
      any = 1'b0;
      g   = 0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!any && en[c] && h[c] < tail[c]) begin
          any = 1'b1;
          g   = c;
        end
      end
      if (!any) break;
      ed.push_back(8'hF0 | 8'(g));
      eg.push_back(g);
      n = 0;
      do begin
        ed.push_back(bd[g][h[g]]);
        eg.push_back(g);
        n++;
        h[g]++;
      end while (!bl[g][h[g]-1] && n < MB && h[g] < tail[g]);
      m_last = g;
    end
  endtask

  task automatic run(input int budget);
    int n = 0;
    while (ed.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("stream_drained", ed.size(), 0);
    cycle();
    cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b0;
    hold = 1'b0;
    cool = 0;
    clear_q();
    drive();
    ed.delete();
    eg.delete();
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    m_last = N - 1;
  endtask

  initial begin
    int tx_n, ta, nab, n, cnt;
    rst       = 1'b0;
    hold      = 1'b0;
    cool      = 0;
    req_data  = '0;
    req_valid = '0;
    req_last  = '0;
    tx_ready  = 1'b0;
    clear_q();
    m_last = N - 1;
    nx     = 0;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_abort", abort, 0);
    chk("rst_grant_id", grant_id, 0);
    rst = 1'b1;

    // Single requester with arbitration latency
    push(1, 8'h41, 0); push(1, 8'h42, 0); push(1, 8'h43, 1);
    en[1] = 1'b1;
    build();
    cycle();
    chk("lat_idle_valid", obs_v, 0);
    cycle();
    chk("lat_tag_valid", obs_v, 1);
    chk("lat_tag_data", obs_d, 8'hF1);
    run(60);
    chk("single_busy", busy, 0);
    chk("single_grant_id", grant_id, 1);
    chk("single_tx_valid", tx_valid, 0);

    // Fairness: 0 and 2, then 0, 2 and 3
    do_reset();
    for (int m = 0; m < 3; m++) begin
      push(0, 8'h10 + 8'(m), 1);
      push(2, 8'h20 + 8'(m), 1);
    end
    en[0] = 1'b1; en[2] = 1'b1;
    build();
    run(200);
    clear_q();
    for (int m = 0; m < 2; m++) begin
      push(0, 8'h30 + 8'(m), 1);
      push(2, 8'h50 + 8'(m), 1);
      push(3, 8'h70 + 8'(m), 1);
    end
    en[0] = 1'b1; en[2] = 1'b1; en[3] = 1'b1;
    build();
    run(200);

    // Burst limit: 6 bytes from requester 0 split into 4 + 2 with new tag
    do_reset();
    for (int m = 0; m < 6; m++) push(0, 8'hB0 + 8'(m), m == 5);
    en[0] = 1'b1;
    build();
    run(200);

    // Randomized rounds, round-robin pointer carried across rounds
    repeat (6) begin
      clear_q();
      for (int i = 0; i < N; i++) begin
        en[i] = 1'b1;
        cnt   = $urandom_range(0, 7);
        for (int j = 0; j < cnt; j++)
          push(i, 8'($urandom_range(0, 255)), (j == cnt - 1) || ($urandom_range(0, 2) == 0));
      end
      build();
      run(600);
    end

    // Stall timeout: requester 2 sends one byte then goes quiet
    do_reset();
    push(2, 8'h5A, 0);
    push(3, 8'hC3, 1);
    en[2] = 1'b1;
    ed.push_back(8'hF2); eg.push_back(2);
    ed.push_back(8'h5A); eg.push_back(2);
    ed.push_back(8'hF3); eg.push_back(3);
    ed.push_back(8'hC3); eg.push_back(3);
    nx = 0; tx_n = -100; ta = -1; nab = 0;
    for (n = 0; n < 60; n++) begin
      cycle();
      if (n == 3) en[3] = 1'b1;
      if (obs_x && nx == 2) tx_n = n;
      if (obs_ab) begin
        nab++;
        if (ta < 0) ta = n;
        chk("abort_busy", obs_busy, 0);
      end
    end
    chk("abort_count", nab, 1);
    chk("abort_delay", ta - tx_n, 9);
    chk("stall_stream_drained", ed.size(), 0);
    m_last = 3;

    // Reset mid-message while tx_valid is high in S_DATA
    clear_q();
    for (int m = 0; m < 4; m++) push(1, 8'hD0 + 8'(m), m == 3);
    push(3, 8'hE7, 1);
    en[1] = 1'b1; en[3] = 1'b1;
    build();
    nx = 0; n = 0;
    while (nx < 2 && n < 40) begin
      cycle();
      n++;
    end
    chk("pre_rst_progress", nx, 2);
    cycle();
    chk("pre_rst_tx_valid", obs_v, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cool = 0;
    m_last = N - 1;
    ed.delete();
    eg.delete();
    build();
    run(200);

    // Driver stall of 500 cycles inside S_DATA with valid held
    clear_q();
    push(0, 8'hA1, 0);
    push(0, 8'hA2, 1);
    en[0] = 1'b1;
    build();
    nx = 0; n = 0;
    while (nx < 1 && n < 40) begin
      cycle();
      n++;
    end
    chk("drv_tag_sent", nx, 1);
    hold = 1'b1;
    nab  = 0;
    repeat (500) begin
      cycle();
      if (obs_ab) nab++;
    end
    chk("drv_no_abort", nab, 0);
    chk("drv_no_xfer", nx, 1);
    chk("drv_tx_valid", obs_v, 1);
    chk("drv_tx_data", obs_d, 8'hA1);
    hold = 1'b0;
    run(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
